alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset, named clk and rst_n as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr  input  8  [7:6]=opcode, [5:4]=rd, [3:2]=rs1, [1:0]=rs2.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 ld_valid  input  1  direct register write request.
REQ-008 ld_addr  input  2  target register of the direct write.
REQ-009 ld_data  input  4  value of the direct write.
REQ-010 alu_a  output  4  operand A to the 4-bit ALU.
REQ-011 alu_b  output  4  operand B to the 4-bit ALU.
REQ-012 alu_opcode  output  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
REQ-013 alu_result  input  4  combinational ALU result.
REQ-014 alu_zero  input  1  ALU zero flag.
REQ-015 done  output  1  one-cycle pulse; instruction retired.
REQ-016 result_out  output  4  result of the last retired instruction.
REQ-017 zero_flag  output  1  zero flag of the last retired instruction.
REQ-018 dbg_addr  input  2  register-file debug read address.
REQ-019 dbg_data  output  4  combinational read of rf[dbg_addr].

Function
REQ-020 SHALL contain a register file rf[0..3] of four 4-bit registers.
REQ-021 SHALL implement FSM states IDLE, EXEC and WB.
REQ-022 IDLE: instr_ready=1; instr_valid=1 at an edge latches opcode/rd/rs1/rs2 and moves to EXEC; otherwise stays in IDLE.
REQ-023 EXEC: alu_a=rf[rs1], alu_b=rf[rs2], alu_opcode=latched opcode; alu_result and alu_zero are captured into internal registers at the edge; the next state is WB.
REQ-024 Outside EXEC, alu_a, alu_b and alu_opcode SHALL be 0.
REQ-025 WB: rf[rd] takes the captured result, result_out and zero_flag update at the edge, done=1 for exactly this cycle, and the next state is IDLE.
REQ-026 instr_ready=0 in EXEC and WB; instr_valid is ignored there and no instruction is dropped or queued.
REQ-027 Latency: instruction accepted at edge N, done high in the cycle after edge N+1, and the next instruction is accepted at edge N+3 at the earliest.
REQ-028 Result wraps modulo 16; the block adds no carry or borrow handling.
REQ-029 ld_valid SHALL write rf[ld_addr]=ld_data at the edge in any state.
REQ-030 ld_valid in EXEC: operands are read before the load takes effect (old value used).
REQ-031 ld_valid in WB with ld_addr==rd: the writeback wins and the load is discarded.
REQ-032 rs1==rs2 and rd equal to a source register SHALL be legal; the source values are those present during EXEC.
REQ-033 result_out and zero_flag SHALL hold their values between retirements.

Reset
REQ-034 rst_n=0 at an edge SHALL force state IDLE, rf[0..3]=0, result_out=0, zero_flag=0, done=0 and clear the latched instruction fields, in any state.
REQ-035 Reset asserted in EXEC or WB SHALL abort the instruction: no rf write and no done pulse.
REQ-036 During reset, instr_ready SHALL be 0; after release, it is 1 in IDLE.

Verification
REQ-037 The bench SHALL connect the team's 4-bit ALU to alu_a/alu_b/alu_opcode/alu_result/alu_zero.
REQ-038 Load r0=5, r1=3, then issue ADD r2,r0,r1 -> done two cycles after acceptance, result_out=8, zero_flag=0, rf[2]=8.
REQ-039 From that state: SUB r3,r0,r1 -> 2; AND -> 1; OR -> 7, each with zero_flag=0.
REQ-040 Load r0=1, then issue SUB r2,r0,r0 -> result_out=0, zero_flag=1; then load r1=15 and issue ADD r2,r1,r0 -> 0 (wrap), zero_flag=1.
REQ-041 Hold instr_valid high continuously -> instructions are accepted only in IDLE, one every 3 cycles, and the done count equals the accept count.
REQ-042 Load to rs1 during EXEC -> the result uses the old rs1 value; load to rd during WB -> rf[rd] holds the ALU result.
REQ-043 Assert rst_n=0 during EXEC -> no done pulse, all rf=0, result_out=0, zero_flag=0, and instr_ready=1 one cycle after release.

Source files
------------

// File: rtl/alu_ctrl.sv
// Purpose: sequences 8-bit register-to-register instructions onto an external 4-bit ALU and keeps a 4-entry register file.
// Latency: accept at edge N, done pulses in the cycle after edge N+1, next accept at edge N+3 at the earliest.
// Backpressure: instr_ready is low in EXEC/WB and during reset; instr_valid is ignored then, and nothing is queued.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   instr_valid/instr/instr_ready   instruction handshake, instr = {opcode, rd, rs1, rs2}
//   ld_valid/ld_addr/ld_data        direct register write, accepted in any state
//   alu_a/alu_b/alu_opcode          ALU operands, driven only in EXEC (zero otherwise)
//   alu_result/alu_zero             combinational ALU response, captured at the end of EXEC
//   done/result_out/zero_flag       retirement pulse and last retired result/flag
//   dbg_addr/dbg_data               combinational register-file read port
module alu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    input  logic       ld_valid,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_opcode,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    output logic       done,
    output logic [3:0] result_out,
    output logic       zero_flag,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [1:0]      rd_q, rd_d;
    logic [1:0]      rs1_q, rs1_d;
    logic [1:0]      rs2_q, rs2_d;
    logic [3:0]      res_q, res_d;      // ALU result captured at the end of EXEC
    logic            zf_q, zf_d;        // ALU zero flag captured at the end of EXEC
    logic [3:0]      result_q, result_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic [3:0][3:0] rf_q, rf_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        res_d    = res_q;
        zf_d     = zf_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        rf_d     = rf_q;

        // Direct load first so the writeback below overrides it on an rd collision.
        if (ld_valid) begin
            rf_d[ld_addr] = ld_data;
        end

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = instr[7:6];
                    rd_d    = instr[5:4];
                    rs1_d   = instr[3:2];
                    rs2_d   = instr[1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zf_d    = alu_zero;
                done_d  = 1'b1;             // done is registered, so it is high throughout WB
                state_d = WB;
            end
            WB: begin
                rf_d[rd_q] = res_q;
                result_d   = res_q;
                zero_d     = zf_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            rd_q     <= 2'd0;
            rs1_q    <= 2'd0;
            rs2_q    <= 2'd0;
            res_q    <= 4'd0;
            zf_q     <= 1'b0;
            result_q <= 4'd0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            rf_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            res_q    <= res_d;
            zf_q     <= zf_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            rf_q     <= rf_d;
        end
    end

    // rst_n gates the handshake and the pulse so a reset held during WB
    // shows neither readiness nor a retirement.
    assign instr_ready = rst_n && (state_q == IDLE);
    assign done        = rst_n && done_q;

    assign alu_a      = (state_q == EXEC) ? rf_q[rs1_q] : 4'd0;
    assign alu_b      = (state_q == EXEC) ? rf_q[rs2_q] : 4'd0;
    assign alu_opcode = (state_q == EXEC) ? op_q        : 2'd0;

    assign result_out = result_q;
    assign zero_flag  = zero_q;
    assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_ctrl.sv
// Purpose: directed self-checking bench for alu_ctrl with a behavioural 4-bit ALU attached.
// Latency: every step advances one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: the held-valid step checks that instructions are taken only when instr_ready is high.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       done;
    logic [3:0] result_out;
    logic       zero_flag;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .done        (done),
        .result_out  (result_out),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // 4-bit ALU: results wrap modulo 16.
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end
    assign alu_zero = (alu_result == 4'd0);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_chk(input logic [1:0] a, input logic [3:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, {4'd0, dbg_data}, {4'd0, exp});
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    // Issue one instruction from IDLE and follow it to retirement.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] exp_res, input logic exp_z,
                         input string tag);
        check({tag, "_ready"}, {7'd0, instr_ready}, 8'd1);
        instr_valid = 1'b1;
        instr       = {op, rd, rs1, rs2};
        tick();                                     // accepted; now EXEC
        instr_valid = 1'b0;
        check({tag, "_exec_done"}, {7'd0, done}, 8'd0);
        check({tag, "_exec_op"}, {6'd0, alu_opcode}, {6'd0, op});
        tick();                                     // now WB
        check({tag, "_wb_done"}, {7'd0, done}, 8'd1);
        check({tag, "_wb_alu_ab"}, {alu_a, alu_b}, 8'd0);
        tick();                                     // back in IDLE
        check({tag, "_idle_done"}, {7'd0, done}, 8'd0);
        check({tag, "_result"}, {4'd0, result_out}, {4'd0, exp_res});
        check({tag, "_zero"}, {7'd0, zero_flag}, {7'd0, exp_z});
        rf_chk(rd, exp_res, {tag, "_rf_rd"});
    endtask

    initial begin
        int acc_cnt;
        int done_cnt;
        int last_acc;
        int done_seen;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'd0;
        ld_valid    = 1'b0;
        ld_addr     = 2'd0;
        ld_data     = 4'd0;
        dbg_addr    = 2'd0;

        // Reset state
        tick();
        tick();
        check("rst_ready", {7'd0, instr_ready}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_result", {4'd0, result_out}, 8'd0);
        check("rst_zero", {7'd0, zero_flag}, 8'd0);
        check("rst_alu_a", {4'd0, alu_a}, 8'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", {7'd0, instr_ready}, 8'd1);
        tick();

        // r0=5, r1=3 arithmetic and logic
        load(2'd0, 4'd5);
        load(2'd1, 4'd3);
        rf_chk(2'd0, 4'd5, "ld_r0");
        issue(OP_ADD, 2'd2, 2'd0, 2'd1, 4'd8, 1'b0, "add");
        issue(OP_SUB, 2'd3, 2'd0, 2'd1, 4'd2, 1'b0, "sub");
        issue(OP_AND, 2'd3, 2'd0, 2'd1, 4'd1, 1'b0, "and");
        issue(OP_OR,  2'd3, 2'd0, 2'd1, 4'd7, 1'b0, "or");

        // Result and flag hold while idle
        tick();
        tick();
        check("hold_result", {4'd0, result_out}, 8'd7);
        check("hold_zero", {7'd0, zero_flag}, 8'd0);

        // Zero results: same-source subtract and wrapping add
        load(2'd0, 4'd1);
        issue(OP_SUB, 2'd2, 2'd0, 2'd0, 4'd0, 1'b1, "sub_self");
        load(2'd1, 4'd15);
        issue(OP_ADD, 2'd2, 2'd1, 2'd0, 4'd0, 1'b1, "add_wrap");

        // instr_valid held high for 30 cycles: ADD r3,r0,r0 = 2
        acc_cnt   = 0;
        done_cnt  = 0;
        last_acc  = -1;
        instr     = {OP_ADD, 2'd3, 2'd0, 2'd0};
        instr_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (done) done_cnt++;
            if (instr_ready) begin
                if (last_acc >= 0) check("stream_gap", 8'(c - last_acc), 8'd3);
                last_acc = c;
                acc_cnt++;
            end
            tick();
        end
        instr_valid = 1'b0;
        check("stream_acc", 8'(acc_cnt), 8'd10);
        check("stream_done", 8'(done_cnt), 8'(acc_cnt));
        tick();
        rf_chk(2'd3, 4'd2, "stream_rf3");

        // Load to rs1 during EXEC, load to rd during WB: SUB r3,r1,r0 = 15-1 = 14
        instr_valid = 1'b1;
        instr       = {OP_SUB, 2'd3, 2'd1, 2'd0};
        tick();                                     // EXEC
        instr_valid = 1'b0;
        ld_valid    = 1'b1;
        ld_addr     = 2'd1;
        ld_data     = 4'd0;
        check("hz_exec_a", {4'd0, alu_a}, 8'd15);
        tick();                                     // WB
        ld_addr     = 2'd3;
        ld_data     = 4'd9;
        check("hz_wb_done", {7'd0, done}, 8'd1);
        tick();                                     // IDLE
        ld_valid    = 1'b0;
        check("hz_result", {4'd0, result_out}, 8'd14);
        rf_chk(2'd3, 4'd14, "hz_rf3");
        rf_chk(2'd1, 4'd0, "hz_rf1");

        // Reset during EXEC aborts the instruction
        instr_valid = 1'b1;
        instr       = {OP_ADD, 2'd2, 2'd0, 2'd0};
        tick();                                     // EXEC
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("rx_ready_in_rst", {7'd0, instr_ready}, 8'd0);
        tick();
        check("rx_done", {7'd0, done}, 8'd0);
        rst_n = 1'b1;
        #1;
        check("rx_ready", {7'd0, instr_ready}, 8'd1);
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) done_seen++;
        end
        check("rx_no_done", 8'(done_seen), 8'd0);
        check("rx_result", {4'd0, result_out}, 8'd0);
        check("rx_zero", {7'd0, zero_flag}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            rf_chk(2'(i), 4'd0, "rx_rf");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
